// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Latency: n/a (types, constants and a pure length helper only).
// Backpressure: n/a.
package fd_pkg;

    localparam int INST_W = 48;
    localparam int PC_W   = 32;

    localparam logic [2:0] FIXED_LEN = 3'd4;
    localparam logic [2:0] MAX_LEN   = 3'd6;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   next_pc;
        logic              mode;
    } fd_entry_t;

    // Fixed-length ISA is always 4 bytes. Variable-length entries never straddle
    // a redirect, so the low bits of the PC delta are the true byte length.
    function automatic logic [2:0] inst_len(input fd_entry_t e);
        logic [PC_W-1:0] diff;
        diff = e.next_pc - e.pc;
        return e.mode ? diff[2:0] : FIXED_LEN;
    endfunction

endpackage

// File: rtl/fd_fifo_mem.sv
// Register-array storage for queue entries: one write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner decides when we is asserted. Data is not reset.
module fd_fifo_mem
    import fd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  fd_entry_t       wdata,
    input  logic [AW-1:0]   raddr,
    output fd_entry_t       rdata
);

    fd_entry_t mem_q [DEPTH];
    fd_entry_t mem_d [DEPTH];

    // Next contents: hold everything, overwrite the addressed slot on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register; payload needs no reset since occupancy lives in the top.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fd_inst_queue.sv
// Fetch-to-decode instruction queue (circular buffer); FD_QUEUE_BYPASS_EN adds an empty-queue bypass.
// Latency: 1 cycle push-to-d_valid; 0 cycles when the bypass is enabled and the queue is empty.
// Backpressure: q_full (registered count only) stalls fetch; flush drops all contents next edge.
module fd_inst_queue
    import fd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         f_valid,
    input  logic [INST_W-1:0]            f_inst,
    input  logic [PC_W-1:0]              f_pc,
    input  logic [PC_W-1:0]              f_next_inst_pc,
    input  logic                         f_mode,
    input  logic                         flush,
    output logic                         q_full,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    output logic                         d_valid,
    input  logic                         d_ready,
    output logic [INST_W-1:0]            d_inst,
    output logic [PC_W-1:0]              d_pc,
    output logic [PC_W-1:0]              d_next_pc,
    output logic                         d_mode,
    output logic [2:0]                   d_len
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    fd_entry_t f_entry;
    fd_entry_t rd_entry;
    fd_entry_t head;
    logic      empty;
    logic      byp_vld;
    logic      byp_take;
    logic      head_vld;
    logic      push;
    logic      pop;
    logic      wr_en;
    logic      rd_adv;

    assign f_entry = '{inst: f_inst, pc: f_pc, next_pc: f_next_inst_pc, mode: f_mode};
    assign empty   = (count_q == '0);
    assign q_full  = (count_q == CNT_W'(DEPTH));
    assign q_count = count_q;

    fd_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (f_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Head selection and handshake qualification. A bypassed entry that decode
    // takes immediately never touches storage, so neither pointer moves.
    always_comb begin
        byp_vld  = 1'b0;
`ifdef FD_QUEUE_BYPASS_EN
        byp_vld  = empty & f_valid & ~flush;
`endif
        head_vld = ~empty | byp_vld;
        head     = byp_vld ? f_entry : rd_entry;
        push     = f_valid & ~q_full & ~flush;
        pop      = head_vld & d_ready & ~flush;
        byp_take = byp_vld & d_ready;
        wr_en    = push & ~byp_take;
        rd_adv   = pop & ~byp_take;
    end

    // Pointer/count update; flush wins over any concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_adv})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy state; reset discards contents unconditionally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Decode-side outputs are forced to zero whenever no head is presented.
    always_comb begin
        d_valid   = head_vld;
        d_inst    = '0;
        d_pc      = '0;
        d_next_pc = '0;
        d_mode    = 1'b0;
        d_len     = '0;
        if (head_vld) begin
            d_inst    = head.inst;
            d_pc      = head.pc;
            d_next_pc = head.next_pc;
            d_mode    = head.mode;
            d_len     = inst_len(head);
        end
    end

endmodule
